// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types for the direct-mapped write-back cache: address geometry,
// controller states and the CPU/memory/array request structures.
package cache_def;

    localparam int unsigned TAGMSB      = 31;
    localparam int unsigned TAGLSB      = 11;
    localparam int unsigned INDEX_BIT   = 7;
    localparam int unsigned OFFSET_BITS = 4;
    localparam int unsigned WORD_MSB    = 3;
    localparam int unsigned WORD_LSB    = 2;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } cache_state_type;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAGMSB:TAGLSB] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [INDEX_BIT-1:0] index;
        logic                 we;
    } cache_req_type;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    // Line-aligned byte address rebuilt from a tag and an index.
    function automatic logic [31:0] line_addr(input logic [TAGMSB:TAGLSB] tag,
                                              input logic [INDEX_BIT-1:0] index);
        return {tag, index, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU and memory-side buses of the cache controller; master is the
// CPU/memory environment, slave is the controller.
interface dm_cache_ctrl_if
    import cache_def::*;
;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_req_type    mem_req;
    mem_data_type   mem_data;

    modport master (
        output cpu_req,
        output mem_data,
        input  cpu_res,
        input  mem_req
    );

    modport slave (
        input  cpu_req,
        input  mem_data,
        output cpu_res,
        output mem_req
    );
endinterface

// File: rtl/dm_cache_ctrl_array.sv
// Generic cache storage: combinational read, synchronous write, optional
// synchronous clear of every entry on reset.
module dm_cache_array
    import cache_def::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2 ** INDEX_BIT,
    parameter bit          CLEAR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  cache_req_type    i_req,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_req.index];

    always_ff @(posedge clk) begin
        if (CLEAR && rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_req.we) begin
            r_mem[i_req.index] <= i_wdata;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller: owns the tag and
// data arrays and sequences hit, victim write-back and line refill.
module dm_cache_ctrl
    import cache_def::*;
(
    input  logic           clk,
    input  logic           rst,
    dm_cache_ctrl_if.slave bus
);

    if (TAGLSB != INDEX_BIT + OFFSET_BITS) begin : g_geom_check
        $error("dm_cache_ctrl: TAGLSB must equal INDEX_BIT + 4");
    end

    cache_state_type      r_state;
    logic [TAGMSB:TAGLSB] r_tag;
    logic [INDEX_BIT-1:0] r_index;
    logic [1:0]           r_word;
    logic [31:0]          r_wdata;
    logic                 r_rw;

    cache_tag_type  w_tag_rd;
    cache_tag_type  w_tag_wr;
    cache_data_type w_line_rd;
    cache_data_type w_line_wr;
    cache_req_type  w_tag_req;
    cache_req_type  w_data_req;
    logic           w_hit;
    logic           w_victim_dirty;
    logic [6:0]     w_bit_ofs;
    logic           w_unused;

    assign w_unused       = &{1'b0, bus.cpu_req.addr[1:0]};
    assign w_hit          = w_tag_rd.valid && (w_tag_rd.tag == r_tag);
    assign w_victim_dirty = w_tag_rd.valid && w_tag_rd.dirty;
    assign w_bit_ofs      = {r_word, 5'd0};

    dm_cache_array #(
        .WIDTH ($bits(cache_tag_type)),
        .DEPTH (2 ** INDEX_BIT),
        .CLEAR (1'b1)
    ) u_tag_array (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_tag_req),
        .i_wdata (w_tag_wr),
        .o_rdata (w_tag_rd)
    );

    dm_cache_array #(
        .WIDTH ($bits(cache_data_type)),
        .DEPTH (2 ** INDEX_BIT),
        .CLEAR (1'b0)
    ) u_data_array (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_data_req),
        .i_wdata (w_line_wr),
        .o_rdata (w_line_rd)
    );

    // Outputs are decoded from the registered state so a hit answers in the
    // cycle right after acceptance; the arrays are always indexed by req_q.
    always_comb begin
        bus.cpu_res      = '0;
        bus.mem_req      = '0;
        w_tag_req.index  = r_index;
        w_tag_req.we     = 1'b0;
        w_data_req.index = r_index;
        w_data_req.we    = 1'b0;
        w_tag_wr         = '0;
        w_line_wr        = w_line_rd;
        case (r_state)
            COMPARE: begin
                if (w_hit) begin
                    bus.cpu_res.ready = 1'b1;
                    bus.cpu_res.data  = w_line_rd[w_bit_ofs +: 32];
                    if (r_rw) begin
                        w_line_wr[w_bit_ofs +: 32] = r_wdata;
                        w_data_req.we  = 1'b1;
                        w_tag_wr.valid = 1'b1;
                        w_tag_wr.dirty = 1'b1;
                        w_tag_wr.tag   = r_tag;
                        w_tag_req.we   = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                bus.mem_req.addr  = line_addr(w_tag_rd.tag, r_index);
                bus.mem_req.data  = w_line_rd;
                bus.mem_req.rw    = 1'b1;
                bus.mem_req.valid = 1'b1;
            end
            ALLOCATE: begin
                bus.mem_req.addr  = line_addr(r_tag, r_index);
                bus.mem_req.valid = 1'b1;
                if (bus.mem_data.ready) begin
                    w_line_wr      = bus.mem_data.data;
                    w_data_req.we  = 1'b1;
                    w_tag_wr.valid = 1'b1;
                    w_tag_wr.tag   = r_tag;
                    w_tag_req.we   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tag   <= '0;
            r_index <= '0;
            r_word  <= '0;
            r_wdata <= '0;
            r_rw    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req.valid) begin
                        r_tag   <= bus.cpu_req.addr[TAGMSB:TAGLSB];
                        r_index <= bus.cpu_req.addr[TAGLSB-1:OFFSET_BITS];
                        r_word  <= bus.cpu_req.addr[WORD_MSB:WORD_LSB];
                        r_wdata <= bus.cpu_req.data;
                        r_rw    <= bus.cpu_req.rw;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        r_state <= IDLE;
                    end else if (w_victim_dirty) begin
                        r_state <= WRITE_BACK;
                    end else begin
                        r_state <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (bus.mem_data.ready) begin
                        r_state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_data.ready) begin
                        r_state <= COMPARE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: hand-computed hits, clean and dirty
// misses, slow memory, stray memory ready and reset during write-back.
module tb_dm_cache_ctrl;
    import cache_def::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_cache_ctrl_if bus ();

    dm_cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] mem_model [logic [31:0]];
    int           mem_lat    = 0;
    int           n_unstable = 0;
    logic [31:0]  tx_addr [$];
    logic [127:0] tx_data [$];
    logic         tx_rw   [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one CPU access and plays the memory side until cpu_res.ready.
    // Called just after a rising edge; returns just after the rising edge
    // that ends the ready cycle. lat counts cycles from valid to ready.
    task automatic cpu_access(input logic [31:0] a, input logic [31:0] d, input logic rw,
                              output logic [31:0] rd, output int lat);
        int          wait_cnt;
        bit          done;
        mem_req_type prev;
        wait_cnt = 0;
        done     = 0;
        lat      = 0;
        rd       = '0;
        prev     = '0;
        bus.cpu_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
        while (!done && lat < 200) begin
            @(negedge clk);
            if (bus.cpu_res.ready) begin
                rd   = bus.cpu_res.data;
                done = 1;
            end else if (bus.mem_req.valid) begin
                if (wait_cnt > 0 && bus.mem_req !== prev) n_unstable++;
                prev = bus.mem_req;
                if (wait_cnt == mem_lat) begin
                    tx_addr.push_back(bus.mem_req.addr);
                    tx_data.push_back(bus.mem_req.data);
                    tx_rw.push_back(bus.mem_req.rw);
                    bus.mem_data.ready = 1'b1;
                    if (bus.mem_req.rw) begin
                        mem_model[bus.mem_req.addr] = bus.mem_req.data;
                        bus.mem_data.data = '0;
                    end else begin
                        bus.mem_data.data = mem_model.exists(bus.mem_req.addr) ?
                                            mem_model[bus.mem_req.addr] : '0;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_data = '0;
            if (!done) lat++;
        end
        bus.cpu_req = '0;
        if (!done) check("cpu_access_timeout", 128'd0, 128'd1);
    endtask

    logic [31:0] rd;
    int          lat;
    int          ntx;
    bit          seen;

    initial begin
        bus.cpu_req  = '0;
        bus.mem_data = '0;
        mem_model[32'h0000_1000] = {32'hA3A3_3333, 32'hA2A2_2222, 32'hA1A1_1111, 32'hA0A0_0000};
        mem_model[32'h0000_1800] = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        mem_model[32'h0000_2010] = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        mem_model[32'h0000_2810] = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        mem_model[32'h0000_3000] = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", 128'(bus.mem_req.valid), 128'd0);
        check("rst_mem_addr", 128'(bus.mem_req.addr), 128'd0);
        check("rst_mem_data", bus.mem_req.data, 128'd0);
        check("rst_cpu_ready", 128'(bus.cpu_res.ready), 128'd0);
        check("rst_cpu_data", 128'(bus.cpu_res.data), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Clean read miss, refill from 0x1000
        cpu_access(32'h0000_1004, 32'h0, 1'b0, rd, lat);
        check("miss_rd_data", 128'(rd), 128'hA1A1_1111);
        check("miss_rd_lat", 128'(lat), 128'd3);
        check("miss_rd_ntx", 128'(tx_addr.size()), 128'd1);
        check("miss_rd_addr", 128'(tx_addr[0]), 128'h0000_1000);
        check("miss_rd_rw", 128'(tx_rw[0]), 128'd0);
        check("miss_rd_wdata", tx_data[0], 128'd0);

        // Read hit, and ready only for one cycle
        cpu_access(32'h0000_1008, 32'h0, 1'b0, rd, lat);
        check("hit_rd_data", 128'(rd), 128'hA2A2_2222);
        check("hit_rd_lat", 128'(lat), 128'd1);
        check("hit_rd_ntx", 128'(tx_addr.size()), 128'd1);
        @(negedge clk);
        check("ready_one_cycle", 128'(bus.cpu_res.ready), 128'd0);
        check("idle_data_zero", 128'(bus.cpu_res.data), 128'd0);
        @(posedge clk);
        #1;

        // Write hit then conflicting read: dirty victim written back first
        cpu_access(32'h0000_100C, 32'hDEAD_BEEF, 1'b1, rd, lat);
        check("hit_wr_lat", 128'(lat), 128'd1);
        check("hit_wr_ntx", 128'(tx_addr.size()), 128'd1);
        cpu_access(32'h0000_180C, 32'h0, 1'b0, rd, lat);
        check("dirty_rd_data", 128'(rd), 128'hB000_0003);
        check("dirty_rd_lat", 128'(lat), 128'd4);
        check("dirty_rd_ntx", 128'(tx_addr.size()), 128'd3);
        check("wb_addr", 128'(tx_addr[1]), 128'h0000_1000);
        check("wb_rw", 128'(tx_rw[1]), 128'd1);
        check("wb_data", tx_data[1],
              {32'hDEAD_BEEF, 32'hA2A2_2222, 32'hA1A1_1111, 32'hA0A0_0000});
        check("alloc_addr", 128'(tx_addr[2]), 128'h0000_1800);
        check("alloc_rw", 128'(tx_rw[2]), 128'd0);

        // Write miss to a clean line: refill then merge into word 0
        cpu_access(32'h0000_2010, 32'h1234_5678, 1'b1, rd, lat);
        check("wr_miss_lat", 128'(lat), 128'd3);
        check("wr_miss_ntx", 128'(tx_addr.size()), 128'd4);
        check("wr_miss_addr", 128'(tx_addr[3]), 128'h0000_2010);
        check("wr_miss_rw", 128'(tx_rw[3]), 128'd0);
        cpu_access(32'h0000_2010, 32'h0, 1'b0, rd, lat);
        check("wr_merge_w0", 128'(rd), 128'h1234_5678);
        cpu_access(32'h0000_2014, 32'h0, 1'b0, rd, lat);
        check("wr_merge_w1", 128'(rd), 128'hC000_0001);
        check("wr_merge_ntx", 128'(tx_addr.size()), 128'd4);
        cpu_access(32'h0000_2810, 32'h0, 1'b0, rd, lat);
        check("wr_dirty_lat", 128'(lat), 128'd4);
        check("wr_dirty_wb_addr", 128'(tx_addr[4]), 128'h0000_2010);
        check("wr_dirty_wb_rw", 128'(tx_rw[4]), 128'd1);
        check("wr_dirty_wb_data", tx_data[4],
              {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'h1234_5678});
        check("wr_dirty_rd", 128'(rd), 128'hD000_0000);

        // Slow memory: refill held off for 20 cycles
        mem_lat    = 20;
        n_unstable = 0;
        cpu_access(32'h0000_3004, 32'h0, 1'b0, rd, lat);
        check("slow_lat", 128'(lat), 128'd23);
        check("slow_stable", 128'(n_unstable), 128'd0);
        check("slow_data", 128'(rd), 128'hE000_0001);
        check("slow_addr", 128'(tx_addr[tx_addr.size()-1]), 128'h0000_3000);
        mem_lat = 0;

        // Stray memory ready while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            bus.mem_data = '{data: '1, ready: 1'b1};
            @(negedge clk);
            check("stray_mem_valid", 128'(bus.mem_req.valid), 128'd0);
            check("stray_cpu_ready", 128'(bus.cpu_res.ready), 128'd0);
            @(posedge clk);
            #1;
        end
        bus.mem_data = '0;
        ntx = tx_addr.size();
        cpu_access(32'h0000_3008, 32'h0, 1'b0, rd, lat);
        check("stray_hit_lat", 128'(lat), 128'd1);
        check("stray_hit_data", 128'(rd), 128'hE000_0002);
        check("stray_hit_ntx", 128'(tx_addr.size()), 128'(ntx));

        // Reset during write-back abandons the request and drops dirty data
        cpu_access(32'h0000_3000, 32'h5555_AAAA, 1'b1, rd, lat);
        check("pre_rst_wr_lat", 128'(lat), 128'd1);
        bus.cpu_req = '{addr: 32'h0000_3800, data: 32'h0, rw: 1'b0, valid: 1'b1};
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_req.valid) seen = 1;
        end
        check("wb_seen", 128'(seen), 128'd1);
        check("wb_rst_addr", 128'(bus.mem_req.addr), 128'h0000_3000);
        check("wb_rst_rw", 128'(bus.mem_req.rw), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.cpu_req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wb_valid", 128'(bus.mem_req.valid), 128'd0);
        check("rst_wb_ready", 128'(bus.cpu_res.ready), 128'd0);
        @(posedge clk);
        #1;
        ntx = tx_addr.size();
        cpu_access(32'h0000_3008, 32'h0, 1'b0, rd, lat);
        check("post_rst_lat", 128'(lat), 128'd3);
        check("post_rst_ntx", 128'(tx_addr.size()), 128'(ntx + 1));
        check("post_rst_rw", 128'(tx_rw[tx_rw.size()-1]), 128'd0);
        check("post_rst_addr", 128'(tx_addr[tx_addr.size()-1]), 128'h0000_3000);
        check("post_rst_data", 128'(rd), 128'hE000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
